mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MEM stage of the 5-stage LoongArch pipeline; transmitter of ms_to_ws_bus/ms_to_ws_valid into wb_stage.
//  Holds one instruction from EX, waits for data-SRAM load response, extracts/extends load data,
//  and forwards result to WB. Drives forwarding/load-use info to ID. ws_allowin is its sole backpressure.
// PARAMETERS
//  ES_TO_MS_BUS_WD  74  {ld_type[2:0],res_from_mem,gr_we,dest[4:0],alu_result[31:0],pc[31:0]} (MSB..LSB)
//  MS_TO_WS_BUS_WD  70  {gr_we,dest[4:0],final_result[31:0],pc[31:0]}
//  MS_TO_DS_BUS_WD  39  {fwd_we,load_wait,dest[4:0],fwd_data[31:0]}
// PORTS
//  clk               in   1    clock, rising edge
//  reset             in   1    asynchronous, active-high
//  ms_allowin        out  1    MS can accept from EX this cycle
//  es_to_ms_valid    in   1    EX holds valid instruction
//  es_to_ms_bus      in   ES_TO_MS_BUS_WD  EX payload
//  ws_allowin        in   1    WB can accept this cycle
//  ms_to_ws_valid    out  1    MS offers instruction to WB
//  ms_to_ws_bus      out  MS_TO_WS_BUS_WD  WB payload
//  ms_to_ds_bus      out  MS_TO_DS_BUS_WD  forwarding/hazard info to ID
//  data_sram_data_ok in   1    load response valid (one-cycle pulse)
//  data_sram_rdata   in   32   load response word, valid with data_ok
// BEHAVIOUR
//  State: ms_valid, bus register es_bus_r, rdata_buf[31:0], rdata_buf_valid. Reset (async): ms_valid=0,
//   rdata_buf_valid=0, es_bus_r=0 -> ms_to_ws_valid=0, ms_allowin=1, ms_to_ds_bus=0.
//  ms_ready_go = !res_from_mem | data_sram_data_ok | rdata_buf_valid.
//  ms_allowin = !ms_valid | (ms_ready_go & ws_allowin); ms_to_ws_valid = ms_valid & ms_ready_go.
//  Posedge: if ms_allowin, ms_valid<=es_to_ms_valid; if es_to_ms_valid&ms_allowin, es_bus_r<=es_to_ms_bus.
//  Buffer: ms_valid & res_from_mem & data_ok & !rdata_buf_valid & !ws_allowin -> rdata_buf<=rdata,
//   rdata_buf_valid<=1. Cleared when ms_to_ws_valid & ws_allowin (transfer fires). Set+clear same cycle
//   cannot occur (set requires !ws_allowin).
//  data_ok while !ms_valid, !res_from_mem, or rdata_buf_valid=1: protocol violation, ignored, no state change.
//  Load word source: rdata_buf_valid ? rdata_buf : data_sram_rdata. addr=alu_result[1:0].
//  ld_type: 000 ld.w whole word; 001 ld.b byte[addr*8+:8] sign-ext; 011 ld.bu zero-ext;
//   010 ld.h half addr[1]?[31:16]:[15:0] sign-ext; 100 ld.hu zero-ext; addr[0] ignored for halves;
//   101-111 treated as ld.w.
//  final_result = res_from_mem ? load_result : alu_result. ms_to_ws_bus combinational from es_bus_r.
//  Latency: 1 cycle EX->WB when load response present in MS cycle; otherwise stalls until data_ok.
//  ms_to_ds_bus: fwd_we = ms_valid&gr_we&(dest!=0); load_wait = fwd_we & res_from_mem & !ms_ready_go;
//   fwd_data = final_result (meaningful only when fwd_we & !load_wait).
//  Simultaneous leave+enter: same-cycle WB transfer and EX accept allowed (full throughput, no bubble).
//  Reset mid-load: instruction dropped, buffer invalidated; later stray data_ok ignored per rule above.
// TESTING
//  T1 reset asserted mid-stall -> same cycle ms_to_ws_valid=0, ms_allowin=1, ms_to_ds_bus=0.
//  T2 back-to-back ALU ops (pc 0x1c000000,0x1c000004), ws_allowin=1 -> each on ms_to_ws_bus 1 cycle after accept, no bubble.
//  T3 ld.b addr 0x...03, rdata 0x80FF_1234 same cycle -> final_result 0xFFFF_FF80; ld.bu -> 0x0000_0080.
//  T4 ld.h addr[1]=1, rdata 0x8001_7FFF -> 0xFFFF_8001; ld.hu addr[1]=0 -> 0x0000_7FFF.
//  T5 ld.w, data_ok 3 cycles late -> ms_allowin=0, load_wait=1 for 3 cycles, then ms_to_ws_valid=1.
//  T6 ld.w data_ok with ws_allowin=0 for 2 cycles, rdata 0xDEADBEEF -> buffered; released word 0xDEADBEEF.

Source files
------------

// File: rtl/mem_stage.sv
// MEM stage: holds one EX instruction, waits for the load response,
// aligns and extends load data, and hands the result to WB.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 74,
  parameter int MS_TO_WS_BUS_WD = 70,
  parameter int MS_TO_DS_BUS_WD = 39
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata
);

  logic                       ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_bus_r;
  logic [31:0]                rdata_buf;
  logic                       rdata_buf_valid;

  logic [2:0]  ld_type;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;

  assign {ld_type, res_from_mem, gr_we, dest,
          alu_result, pc} = es_bus_r;

  logic ms_ready_go;
  logic xfer;
  logic buf_set;

  assign ms_ready_go = !res_from_mem
                     | data_sram_data_ok
                     | rdata_buf_valid;

  assign ms_allowin     = !ms_valid
                        | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid & ms_ready_go;
  assign xfer           = ms_to_ws_valid & ws_allowin;

  // Capture the response only when WB stalls it;
  // a second data_ok while buffered is ignored.
  assign buf_set = ms_valid & res_from_mem
                 & data_sram_data_ok
                 & !rdata_buf_valid & !ws_allowin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid <= 1'b0;
      es_bus_r <= '0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
      if (es_to_ms_valid) begin
        es_bus_r <= es_to_ms_bus;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_buf       <= '0;
      rdata_buf_valid <= 1'b0;
    end else if (buf_set) begin
      rdata_buf       <= data_sram_rdata;
      rdata_buf_valid <= 1'b1;
    end else if (xfer) begin
      rdata_buf_valid <= 1'b0;
    end
  end

  logic [31:0] ld_word;
  logic [1:0]  addr;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_word = rdata_buf_valid ? rdata_buf
                                   : data_sram_rdata;
  assign addr    = alu_result[1:0];

  always_comb begin
    ld_byte = ld_word[7:0];
    unique case (addr)
      2'd0: ld_byte = ld_word[7:0];
      2'd1: ld_byte = ld_word[15:8];
      2'd2: ld_byte = ld_word[23:16];
      2'd3: ld_byte = ld_word[31:24];
    endcase
  end

  assign ld_half = addr[1] ? ld_word[31:16]
                           : ld_word[15:0];

  logic is_b;
  logic is_bu;
  logic is_h;
  logic is_hu;

  assign is_b  = (ld_type == 3'b001);
  assign is_bu = (ld_type == 3'b011);
  assign is_h  = (ld_type == 3'b010);
  assign is_hu = (ld_type == 3'b100);

  logic [31:0] load_result;

  always_comb begin
    load_result = ld_word;
    unique case (1'b1)
      is_b:    load_result = {{24{ld_byte[7]}}, ld_byte};
      is_bu:   load_result = {24'd0, ld_byte};
      is_h:    load_result = {{16{ld_half[15]}}, ld_half};
      is_hu:   load_result = {16'd0, ld_half};
      default: load_result = ld_word;
    endcase
  end

  logic [31:0] final_result;

  assign final_result = res_from_mem ? load_result
                                     : alu_result;

  assign ms_to_ws_bus = {gr_we, dest, final_result, pc};

  logic fwd_we;
  logic load_wait;

  assign fwd_we    = ms_valid & gr_we & (dest != 5'd0);
  assign load_wait = fwd_we & res_from_mem & !ms_ready_go;

  assign ms_to_ds_bus = {fwd_we, load_wait, dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, load extension,
// stalls, response buffering and asynchronous reset.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [73:0] es_to_ms_bus;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [38:0] ms_to_ds_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  int n_checks = 0;
  int n_fails  = 0;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_to_ds_bus      (ms_to_ds_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [69:0] obs,
                       input logic [69:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [73:0] mk_bus(
    input logic [2:0]  lt,
    input logic        rfm,
    input logic        we,
    input logic [4:0]  rd,
    input logic [31:0] alu,
    input logic [31:0] pcv);
    return {lt, rfm, we, rd, alu, pcv};
  endfunction

  function automatic logic [69:0] mk_ws(
    input logic [4:0]  rd,
    input logic [31:0] res,
    input logic [31:0] pcv);
    return {1'b1, rd, res, pcv};
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  // Accept a load, then return the response in the next cycle.
  task automatic do_load(input string tag,
                         input logic [2:0]  lt,
                         input logic [31:0] addr,
                         input logic [31:0] rd_word,
                         input logic [31:0] exp);
    cyc();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(lt, 1'b1, 1'b1, 5'd9,
                            addr, 32'h1c00_0100);
    cyc();
    es_to_ms_valid    = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rd_word;
    #1;
    check({tag, "_valid"}, 70'(ms_to_ws_valid), 70'd1);
    check({tag, "_bus"}, ms_to_ws_bus,
          mk_ws(5'd9, exp, 32'h1c00_0100));
    cyc();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
  endtask

  initial begin
    reset             = 1'b1;
    es_to_ms_valid    = 1'b0;
    es_to_ms_bus      = '0;
    ws_allowin        = 1'b1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    #12;
    check("rst_allowin", 70'(ms_allowin), 70'd1);
    check("rst_valid", 70'(ms_to_ws_valid), 70'd0);
    check("rst_ds", 70'(ms_to_ds_bus), 70'd0);
    cyc();
    reset = 1'b0;

    // back-to-back ALU ops
    cyc();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(3'b000, 1'b0, 1'b1, 5'd3,
                            32'h0000_0011, 32'h1c00_0000);
    #1;
    check("alu_allowin", 70'(ms_allowin), 70'd1);
    cyc();
    es_to_ms_bus = mk_bus(3'b000, 1'b0, 1'b1, 5'd4,
                          32'h0000_0022, 32'h1c00_0004);
    #1;
    check("alu0_valid", 70'(ms_to_ws_valid), 70'd1);
    check("alu0_bus", ms_to_ws_bus,
          mk_ws(5'd3, 32'h11, 32'h1c00_0000));
    check("alu0_ds", 70'(ms_to_ds_bus),
          70'({1'b1, 1'b0, 5'd3, 32'h11}));
    check("alu0_allowin", 70'(ms_allowin), 70'd1);
    cyc();
    es_to_ms_valid = 1'b0;
    #1;
    check("alu1_valid", 70'(ms_to_ws_valid), 70'd1);
    check("alu1_bus", ms_to_ws_bus,
          mk_ws(5'd4, 32'h22, 32'h1c00_0004));
    cyc();
    #1;
    check("alu_drain", 70'(ms_to_ws_valid), 70'd0);

    // load extraction
    do_load("ldb", 3'b001, 32'h1000_0003,
            32'h80FF_1234, 32'hFFFF_FF80);
    do_load("ldbu", 3'b011, 32'h1000_0003,
            32'h80FF_1234, 32'h0000_0080);
    do_load("ldb0", 3'b001, 32'h1000_0000,
            32'h80FF_1234, 32'h0000_0034);
    do_load("ldh", 3'b010, 32'h1000_0002,
            32'h8001_7FFF, 32'hFFFF_8001);
    do_load("ldhu", 3'b100, 32'h1000_0000,
            32'h8001_7FFF, 32'h0000_7FFF);
    do_load("ldh_odd", 3'b010, 32'h1000_0003,
            32'h8001_7FFF, 32'hFFFF_8001);
    do_load("ld_111", 3'b111, 32'h1000_0001,
            32'h8001_7FFF, 32'h8001_7FFF);

    // ld.w with a three-cycle late response
    cyc();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(3'b000, 1'b1, 1'b1, 5'd7,
                            32'h1000_0010, 32'h1c00_0200);
    cyc();
    es_to_ms_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("late_allowin", 70'(ms_allowin), 70'd0);
      check("late_wait", 70'(ms_to_ds_bus[37]), 70'd1);
      check("late_valid", 70'(ms_to_ws_valid), 70'd0);
      cyc();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1234_5678;
    #1;
    check("late_done", 70'(ms_to_ws_valid), 70'd1);
    check("late_bus", ms_to_ws_bus,
          mk_ws(5'd7, 32'h1234_5678, 32'h1c00_0200));
    check("late_ds", 70'(ms_to_ds_bus),
          70'({1'b1, 1'b0, 5'd7, 32'h1234_5678}));
    cyc();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;

    // response arrives while WB stalls: must be buffered
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(3'b000, 1'b1, 1'b1, 5'd8,
                            32'h1000_0020, 32'h1c00_0300);
    cyc();
    es_to_ms_valid    = 1'b0;
    ws_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEAD_BEEF;
    #1;
    check("buf_allowin", 70'(ms_allowin), 70'd0);
    cyc();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0BAD_0BAD;
    #1;
    check("buf_valid", 70'(ms_to_ws_valid), 70'd1);
    check("buf_hold", ms_to_ws_bus,
          mk_ws(5'd8, 32'hDEAD_BEEF, 32'h1c00_0300));
    check("buf_wait", 70'(ms_to_ds_bus[37]), 70'd0);
    cyc();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h5555_5555;
    #1;
    check("buf_stray", ms_to_ws_bus,
          mk_ws(5'd8, 32'hDEAD_BEEF, 32'h1c00_0300));
    cyc();
    data_sram_data_ok = 1'b0;
    ws_allowin        = 1'b1;
    #1;
    check("buf_rel", ms_to_ws_bus,
          mk_ws(5'd8, 32'hDEAD_BEEF, 32'h1c00_0300));
    check("buf_rel_allowin", 70'(ms_allowin), 70'd1);
    cyc();
    #1;
    check("buf_empty", 70'(ms_to_ws_valid), 70'd0);

    // reset mid-stall
    cyc();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(3'b000, 1'b1, 1'b1, 5'd6,
                            32'h1000_0030, 32'h1c00_0400);
    cyc();
    es_to_ms_valid = 1'b0;
    #1;
    check("stall_allowin", 70'(ms_allowin), 70'd0);
    reset = 1'b1;
    #1;
    check("mrst_valid", 70'(ms_to_ws_valid), 70'd0);
    check("mrst_allowin", 70'(ms_allowin), 70'd1);
    check("mrst_ds", 70'(ms_to_ds_bus), 70'd0);
    cyc();
    reset = 1'b0;
    cyc();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h7777_7777;
    #1;
    check("mrst_stray", 70'(ms_to_ws_valid), 70'd0);
    cyc();
    data_sram_data_ok = 1'b0;
    #1;
    check("mrst_idle", 70'(ms_to_ws_valid), 70'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
